// File: rtl/spi_block_reader_pkg.sv
// Shared encodings for the SD block reader: FSM states, status codes, token values.
package spi_block_reader_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StTokIssue,
    StTokWait,
    StDatIssue,
    StDatWait,
    StDatHold,
    StCrcHiIssue,
    StCrcHiWait,
    StCrcLoIssue,
    StCrcLoWait,
    StCheck,
    StDone
  } rd_state_e;

  typedef enum logic [1:0] {
    StepIdle,
    StepSkip,
    StepWait
  } step_state_e;

  localparam logic [2:0] ERR_OK            = 3'd0;
  localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_TOKEN_ERROR   = 3'd2;
  localparam logic [2:0] ERR_CRC           = 3'd3;
  localparam logic [2:0] ERR_ABORT         = 3'd4;

  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] TOKEN_IDLE  = 8'hFF;

  // Each byte-issue state is followed by its matching wait state.
  function automatic rd_state_e issue_to_wait(input rd_state_e s);
    case (s)
      StTokIssue:   return StTokWait;
      StDatIssue:   return StDatWait;
      StCrcHiIssue: return StCrcHiWait;
      default:      return StCrcLoWait;
    endcase
  endfunction

endpackage

// File: rtl/spi_block_reader_byte_step.sv
// One shifter byte transfer: pulse start_read, skip one clk, then wait for busy to drop.
module spi_block_reader_byte_step
  import spi_block_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       busy,
  input  logic [7:0] shift_out,
  output logic       start_read,
  output logic       byte_done,
  output logic [7:0] byte_data
);

  step_state_e state_q, state_d;

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StepIdle;
    else     state_q <= state_d;
  end

  // Next state and pulse outputs; busy may still read 0 on the clk right after the pulse.
  always_comb begin
    state_d    = state_q;
    start_read = 1'b0;
    byte_done  = 1'b0;
    unique case (state_q)
      StepIdle: begin
        if (go) begin
          start_read = 1'b1;
          state_d    = StepSkip;
        end
      end
      StepSkip: state_d = StepWait;
      StepWait: begin
        if (!busy) begin
          byte_done = 1'b1;
          state_d   = StepIdle;
        end
      end
      default: state_d = StepIdle;
    endcase
  end

  // The byte is valid in the same clk that byte_done is high.
  assign byte_data = shift_out;

endmodule

// File: rtl/spi_block_reader.sv
// Reads one SD data block through the SPI shifter: token hunt, data stream, CRC16 check.
module spi_block_reader
  import spi_block_reader_pkg::*;
#(
  parameter int unsigned BLOCK_LEN   = 512,
  parameter int unsigned TOKEN_TRIES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        start_read,
  output logic        crc_reset,
  input  logic [7:0]  shift_out,
  input  logic        busy,
  input  logic [15:0] crc_out,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        active,
  output logic        done,
  output logic [2:0]  error
);

  localparam logic [9:0] LAST_IDX  = 10'(BLOCK_LEN - 1);
  localparam logic [7:0] TRY_LIMIT = 8'(TOKEN_TRIES);

  rd_state_e   state_q, state_d;
  logic [7:0]  try_q, try_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [2:0]  error_q, error_d;

  logic       step_go;
  logic       byte_done;
  logic [7:0] byte_data;

  spi_block_reader_byte_step u_step (
    .clk       (clk),
    .rst       (rst),
    .go        (step_go),
    .busy      (busy),
    .shift_out (shift_out),
    .start_read(start_read),
    .byte_done (byte_done),
    .byte_data (byte_data)
  );

  // Block FSM, counters, CRC snapshot and stream registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      try_q      <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= ERR_OK;
    end else begin
      state_q    <= state_d;
      try_q      <= try_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic; abort is honoured only between bytes, never mid-transfer.
  always_comb begin
    state_d    = state_q;
    try_d      = try_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    error_d    = error_q;
    step_go    = 1'b0;
    crc_reset  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StTokIssue;
          try_d   = '0;
          error_d = ERR_OK;
        end
      end
      StTokIssue, StDatIssue, StCrcHiIssue, StCrcLoIssue: begin
        if (abort) begin
          error_d = ERR_ABORT;
          state_d = StDone;
        end else begin
          step_go = 1'b1;
          state_d = issue_to_wait(state_q);
        end
      end
      StTokWait: begin
        if (byte_done) begin
          if (abort) begin
            error_d = ERR_ABORT;
            state_d = StDone;
          end else if (byte_data == TOKEN_START) begin
            crc_reset = 1'b1;
            cnt_d     = '0;
            state_d   = StDatIssue;
          end else if (byte_data == TOKEN_IDLE) begin
            try_d = try_q + 8'd1;
            if (try_q + 8'd1 == TRY_LIMIT) begin
              error_d = ERR_TOKEN_TIMEOUT;
              state_d = StDone;
            end else begin
              state_d = StTokIssue;
            end
          end else begin
            error_d = ERR_TOKEN_ERROR;
            state_d = StDone;
          end
        end
      end
      StDatWait: begin
        if (byte_done) begin
          if (abort) begin
            error_d = ERR_ABORT;
            state_d = StDone;
          end else begin
            rd_data_d  = byte_data;
            rd_valid_d = 1'b1;
            state_d    = StDatHold;
          end
        end
      end
      StDatHold: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          cnt_d      = cnt_q + 10'd1;
          if (abort) begin
            error_d = ERR_ABORT;
            state_d = StDone;
          end else if (cnt_q == LAST_IDX) begin
            // Snapshot now: the CRC bytes themselves must not enter the comparison value.
            snap_d  = crc_out;
            state_d = StCrcHiIssue;
          end else begin
            state_d = StDatIssue;
          end
        end else if (abort) begin
          rd_valid_d = 1'b0;
          error_d    = ERR_ABORT;
          state_d    = StDone;
        end
      end
      StCrcHiWait: begin
        if (byte_done) begin
          if (abort) begin
            error_d = ERR_ABORT;
            state_d = StDone;
          end else begin
            hi_d    = byte_data;
            state_d = StCrcLoIssue;
          end
        end
      end
      StCrcLoWait: begin
        if (byte_done) begin
          if (abort) begin
            error_d = ERR_ABORT;
            state_d = StDone;
          end else begin
            lo_d    = byte_data;
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (abort) error_d = ERR_ABORT;
        else       error_d = ({hi_q, lo_q} == snap_q) ? ERR_OK : ERR_CRC;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign error    = error_q;
  assign active   = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_spi_block_reader.sv
// Bench for spi_block_reader: behavioural shifter/consumer plus a block-level reference model.
module tb_spi_block_reader;

  localparam int BL = 512;
  localparam int TT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic        start_read, crc_reset;
  logic [7:0]  shift_out;
  logic        busy;
  logic [15:0] crc_out;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_ready;
  logic        active, done;
  logic [2:0]  error;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spi_block_reader #(
    .BLOCK_LEN  (BL),
    .TOKEN_TRIES(TT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .start_read(start_read),
    .crc_reset (crc_reset),
    .shift_out (shift_out),
    .busy      (busy),
    .crc_out   (crc_out),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .active    (active),
    .done      (done),
    .error     (error)
  );

  // CRC16-CCITT (poly 0x1021, init 0) as used by SD data blocks.
  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // MISO byte stream for the current block; bytes past the end read as 0xFF.
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         exp_steps;
  logic [2:0] exp_err;
  int         gen = 0;

  // Shifter model: random shift time, CRC accumulates each received byte.
  int         seen_gen, ptr, shift_cnt;
  logic [7:0] cur_byte;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; shift_out <= 8'h00; crc_out <= 16'h0;
      shift_cnt <= 0; ptr <= 0; seen_gen <= gen; cur_byte <= 8'hFF;
    end else begin
      if (crc_reset) crc_out <= 16'h0;
      if (gen != seen_gen) begin
        seen_gen <= gen;
        ptr      <= 0;
      end else if (start_read) begin
        busy      <= 1'b1;
        shift_cnt <= $urandom_range(1, 4);
        cur_byte  <= (ptr < stim_q.size()) ? stim_q[ptr] : 8'hFF;
        ptr       <= ptr + 1;
      end else if (busy) begin
        shift_cnt <= shift_cnt - 1;
        if (shift_cnt == 1) begin
          busy      <= 1'b0;
          shift_out <= cur_byte;
          crc_out   <= crc16(crc_out, cur_byte);
        end
      end
    end
  end

  // Event counters and consumer capture.
  int         n_sr = 0, n_sr_valid = 0, n_sr_busy = 0, n_crc = 0, n_valid = 0, n_done = 0;
  logic [2:0] done_err = 3'd0;
  always @(posedge clk) begin
    if (!rst) begin
      if (start_read) n_sr <= n_sr + 1;
      if (start_read && rd_valid) n_sr_valid <= n_sr_valid + 1;
      if (start_read && busy) n_sr_busy <= n_sr_busy + 1;
      if (crc_reset) n_crc <= n_crc + 1;
      if (rd_valid) n_valid <= n_valid + 1;
      if (rd_valid && rd_ready) rx_q.push_back(rd_data);
      if (done) begin
        n_done   <= n_done + 1;
        done_err <= error;
      end
    end
  end

  int b_sr, b_sr_valid, b_sr_busy, b_crc, b_valid, b_done, rx_base;

  task automatic build_block(input int n_ff, input logic [7:0] token, input bit counting,
                             input bit flip_lo);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'h0;
    stim_q.delete();
    for (int i = 0; i < n_ff; i++) stim_q.push_back(8'hFF);
    stim_q.push_back(token);
    if (token == 8'hFE) begin
      for (int i = 0; i < BL; i++) begin
        d = counting ? 8'(i) : 8'($urandom);
        stim_q.push_back(d);
        c = crc16(c, d);
      end
      stim_q.push_back(c[15:8]);
      stim_q.push_back(flip_lo ? ~c[7:0] : c[7:0]);
    end
  endtask

  // Reference: what a correct reader does with stim_q, computed straight from the block format.
  task automatic model_block();
    int          i, tries;
    logic [7:0]  b, hi, lo;
    logic [15:0] c;
    i = 0; tries = 0; c = 16'h0;
    exp_q.delete();
    exp_err = 3'd0;
    forever begin
      b = (i < stim_q.size()) ? stim_q[i] : 8'hFF;
      i++;
      if (b == 8'hFE) break;
      if (b != 8'hFF) begin
        exp_err = 3'd2; exp_steps = i; return;
      end
      tries++;
      if (tries == TT) begin
        exp_err = 3'd1; exp_steps = i; return;
      end
    end
    for (int k = 0; k < BL; k++) begin
      b = stim_q[i]; i++;
      exp_q.push_back(b);
      c = crc16(c, b);
    end
    hi = stim_q[i]; lo = stim_q[i + 1];
    exp_steps = i + 2;
    exp_err = ({hi, lo} == c) ? 3'd0 : 3'd3;
  endtask

  task automatic launch();
    rx_base = rx_q.size();
    b_sr = n_sr; b_sr_valid = n_sr_valid; b_sr_busy = n_sr_busy;
    b_crc = n_crc; b_valid = n_valid; b_done = n_done;
    gen++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int base;
    base = n_done;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (n_done != base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({start_read, crc_reset, rd_valid, active, done} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl got %b want 00000",
               {start_read, crc_reset, rd_valid, active, done});
    end
    compared++;
    if (rd_data !== 8'h00) begin
      mismatched++; $display("FAIL reset_rd_data got %h want 00", rd_data);
    end
    compared++;
    if (error !== 3'd0) begin
      mismatched++; $display("FAIL reset_error got %0d want 0", error);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    int bad;
    build_block(3, 8'hFE, 1'b1, 1'b0);
    model_block();
    rd_ready = 1'b1;
    launch();
    repeat (40) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;  // must be ignored while active
    wait_done(20000, to);
    compared++;
    if (to !== 1'b0) begin mismatched++; $display("FAIL basic_timeout got done=0 want done=1"); end
    compared++;
    if (active !== 1'b0) begin mismatched++; $display("FAIL basic_active got %b want 0", active); end
    compared++;
    if (done_err !== exp_err || error !== exp_err) begin
      mismatched++; $display("FAIL basic_error got %0d/%0d want %0d", done_err, error, exp_err);
    end
    compared++;
    if (rx_q.size() - rx_base !== BL) begin
      mismatched++; $display("FAIL basic_count got %0d want %0d", rx_q.size() - rx_base, BL);
    end
    bad = 0;
    for (int k = 0; k < exp_q.size() && rx_base + k < rx_q.size(); k++)
      if (rx_q[rx_base + k] !== exp_q[k]) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL basic_data got %0d bad bytes want 0", bad); end
    compared++;
    if (n_sr - b_sr !== exp_steps) begin
      mismatched++; $display("FAIL basic_steps got %0d want %0d", n_sr - b_sr, exp_steps);
    end
    compared++;
    if (n_crc - b_crc !== 1 || n_done - b_done !== 1) begin
      mismatched++;
      $display("FAIL basic_pulses got crc_reset=%0d done=%0d want 1/1", n_crc - b_crc,
               n_done - b_done);
    end
    compared++;
    if (n_sr_busy - b_sr_busy !== 0) begin
      mismatched++; $display("FAIL basic_sr_busy got %0d want 0", n_sr_busy - b_sr_busy);
    end
  endtask

  task automatic test_timeout();
    bit to;
    stim_q.delete();
    model_block();
    launch();
    wait_done(2000, to);
    compared++;
    if (to !== 1'b0) begin mismatched++; $display("FAIL tmo_timeout got done=0 want done=1"); end
    compared++;
    if (n_sr - b_sr !== exp_steps || exp_steps !== TT) begin
      mismatched++; $display("FAIL tmo_steps got %0d want %0d", n_sr - b_sr, TT);
    end
    compared++;
    if (done_err !== exp_err) begin
      mismatched++; $display("FAIL tmo_error got %0d want %0d", done_err, exp_err);
    end
    compared++;
    if (n_valid - b_valid !== 0 || n_crc - b_crc !== 0) begin
      mismatched++;
      $display("FAIL tmo_quiet got valid=%0d crc_reset=%0d want 0/0", n_valid - b_valid,
               n_crc - b_crc);
    end
  endtask

  task automatic test_error_token();
    bit to;
    build_block(2, 8'h09, 1'b0, 1'b0);
    model_block();
    launch();
    wait_done(2000, to);
    compared++;
    if (to !== 1'b0) begin mismatched++; $display("FAIL etok_timeout got done=0 want done=1"); end
    compared++;
    if (done_err !== exp_err) begin
      mismatched++; $display("FAIL etok_error got %0d want %0d", done_err, exp_err);
    end
    compared++;
    if (n_sr - b_sr !== exp_steps) begin
      mismatched++; $display("FAIL etok_steps got %0d want %0d", n_sr - b_sr, exp_steps);
    end
    compared++;
    if (n_crc - b_crc !== 0) begin
      mismatched++; $display("FAIL etok_crc_reset got %0d want 0", n_crc - b_crc);
    end
  endtask

  task automatic test_bad_crc();
    bit to;
    int bad;
    build_block($urandom_range(0, TT - 1), 8'hFE, 1'b0, 1'b1);
    model_block();
    launch();
    wait_done(20000, to);
    compared++;
    if (to !== 1'b0) begin mismatched++; $display("FAIL bcrc_timeout got done=0 want done=1"); end
    compared++;
    if (done_err !== exp_err) begin
      mismatched++; $display("FAIL bcrc_error got %0d want %0d", done_err, exp_err);
    end
    bad = (rx_q.size() - rx_base == BL) ? 0 : 1;
    for (int k = 0; k < exp_q.size() && rx_base + k < rx_q.size(); k++)
      if (rx_q[rx_base + k] !== exp_q[k]) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL bcrc_data got %0d bad want 0", bad); end
  endtask

  task automatic test_slow_ready();
    bit to, tog_stop;
    int bad;
    build_block($urandom_range(0, TT - 1), 8'hFE, 1'b0, 1'b0);
    model_block();
    tog_stop = 1'b0;
    rd_ready = 1'b0;
    launch();
    fork
      begin
        for (int c = 0; !tog_stop; c++) begin
          @(negedge clk);
          rd_ready = (c % 5 == 0);
        end
      end
      begin
        wait_done(40000, to);
        tog_stop = 1'b1;
      end
    join
    rd_ready = 1'b1;
    compared++;
    if (to !== 1'b0) begin mismatched++; $display("FAIL slow_timeout got done=0 want done=1"); end
    compared++;
    if (done_err !== exp_err) begin
      mismatched++; $display("FAIL slow_error got %0d want %0d", done_err, exp_err);
    end
    bad = (rx_q.size() - rx_base == BL) ? 0 : 1;
    for (int k = 0; k < exp_q.size() && rx_base + k < rx_q.size(); k++)
      if (rx_q[rx_base + k] !== exp_q[k]) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL slow_data got %0d bad want 0", bad); end
    compared++;
    if (n_sr_valid - b_sr_valid !== 0) begin
      mismatched++; $display("FAIL slow_prefetch got %0d want 0", n_sr_valid - b_sr_valid);
    end
  endtask

  task automatic test_abort();
    bit to, hit;
    int bad, sr_at;
    // Abort while idle must not start anything.
    abort = 1'b1;
    b_done = n_done;
    repeat (4) @(negedge clk);
    compared++;
    if (active !== 1'b0 || n_done != b_done) begin
      mismatched++; $display("FAIL idle_abort got active=%b want 0", active);
    end
    abort = 1'b0;
    build_block(2, 8'hFE, 1'b0, 1'b0);
    model_block();
    rd_ready = 1'b1;
    launch();
    hit = 1'b0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge clk);
      if (n_sr - b_sr == 104 && busy) hit = 1'b1;  // data byte 100 in flight
    end
    abort = 1'b1;
    sr_at = n_sr;
    wait_done(2000, to);
    compared++;
    if (hit !== 1'b1 || to !== 1'b0) begin
      mismatched++; $display("FAIL abort_reach got hit=%b timeout=%b want 1/0", hit, to);
    end
    compared++;
    if (done_err !== 3'd4) begin
      mismatched++; $display("FAIL abort_error got %0d want 4", done_err);
    end
    compared++;
    if (n_sr !== sr_at || busy !== 1'b0 || rd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_quiet got extra_sr=%0d busy=%b rd_valid=%b want 0/0/0",
               n_sr - sr_at, busy, rd_valid);
    end
    bad = (rx_q.size() - rx_base == 100) ? 0 : 1;
    for (int k = 0; k < 100 && rx_base + k < rx_q.size(); k++)
      if (rx_q[rx_base + k] !== exp_q[k]) bad++;
    compared++;
    if (bad !== 0) begin
      mismatched++; $display("FAIL abort_prefix got %0d bytes/%0d bad want 100/0",
                             rx_q.size() - rx_base, bad);
    end
    abort = 1'b0;
    @(negedge clk);
    build_block($urandom_range(0, TT - 1), 8'hFE, 1'b0, 1'b0);
    model_block();
    launch();
    wait_done(20000, to);
    bad = (rx_q.size() - rx_base == BL && !to) ? 0 : 1;
    for (int k = 0; k < exp_q.size() && rx_base + k < rx_q.size(); k++)
      if (rx_q[rx_base + k] !== exp_q[k]) bad++;
    compared++;
    if (bad !== 0 || done_err !== 3'd0) begin
      mismatched++; $display("FAIL post_abort got err=%0d bad=%0d want 0/0", done_err, bad);
    end
  endtask

  task automatic test_reset_mid();
    build_block(1, 8'hFE, 1'b0, 1'b0);
    launch();
    repeat (60) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if ({active, rd_valid, start_read, done, error} !== 7'b0) begin
      mismatched++;
      $display("FAIL rst_mid got act=%b vld=%b sr=%b done=%b err=%0d want all 0", active,
               rd_valid, start_read, done, error);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_error_token();
    test_bad_crc();
    test_slow_ready();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
